yarvi_hazard_scoreboard: RTL

Register scoreboard between the decode stage's register-usage decoder and issue. It tracks destination registers with outstanding long-latency writes (loads, mul/div) and stalls decode on RAW and WAW hazards and on serializing instructions. Busy state is set when a long-latency op issues and cleared on that op's writeback. It also tracks the number of outstanding writes.

---
 rtl/yarvi_hazard_scoreboard_pkg.sv | 26 ++
 rtl/yarvi_sb_hazard.sv | 31 +++
 rtl/yarvi_hazard_scoreboard.sv | 125 ++++++++++++
 3 files changed

// File: rtl/yarvi_hazard_scoreboard_pkg.sv
// Shared definitions for the YARVI register scoreboard: register-file size,
// register index type and the instruction register-field decoder.
package yarvi_hazard_scoreboard_pkg;

    localparam int NREGS_DEF = 32;
    localparam int REG_W     = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    // Register operand fields of a RISC-V instruction.
    typedef struct packed {
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
    } insn_regs_t;

    // Single place where the rs1/rs2/rd positions are defined.
    function automatic insn_regs_t decode_regs(input logic [31:0] insn);
        insn_regs_t r;
        r.rs1 = insn[19:15];
        r.rs2 = insn[24:20];
        r.rd  = insn[11:7];
        return r;
    endfunction

endpackage

// File: rtl/yarvi_sb_hazard.sv
// Combinational hazard detector: RAW on rs1/rs2, WAW on rd, and serializing
// instructions waiting for all outstanding writes to drain.
module yarvi_sb_hazard
    import yarvi_hazard_scoreboard_pkg::*;
#(
    parameter int NREGS = NREGS_DEF
) (
    input  logic [NREGS-1:0] busy_chk,
    input  insn_regs_t       regs,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic             writes_rd,
    input  logic             serialize,
    output logic             hazard
);

    logic w_raw_rs1;
    logic w_raw_rs2;
    logic w_waw;
    logic w_ser;

    // use_rs* are already 0 for x0, so no zero test is needed on the sources.
    assign w_raw_rs1 = use_rs1 & busy_chk[regs.rs1];
    assign w_raw_rs2 = use_rs2 & busy_chk[regs.rs2];
    // WAW applies to short writers too so a late long write cannot clobber them.
    assign w_waw     = writes_rd & (regs.rd != '0) & busy_chk[regs.rd];
    assign w_ser     = serialize & (|busy_chk);

    assign hazard = w_raw_rs1 | w_raw_rs2 | w_waw | w_ser;

endmodule

// File: rtl/yarvi_hazard_scoreboard.sv
// YARVI register scoreboard: tracks registers with outstanding long-latency
// writes, stalls decode on RAW/WAW/serialize hazards, counts pending writes.
// Optional feature macro: YARVI_SB_WB_BYPASS_EN (same-cycle writeback releases
// the hazard; same-register set+clear becomes legal).
module yarvi_hazard_scoreboard
    import yarvi_hazard_scoreboard_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [31:0]      dec_insn,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic             dec_writes_rd,
    input  logic             dec_long,
    input  logic             dec_serialize,
    output logic             dec_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             quiescent
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NREGS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NREGS-1:0] r_busy;
    logic [CNT_W-1:0] r_cnt;

    insn_regs_t       w_regs;
    logic             w_rd_nz;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_busy_chk;
    logic             w_hazard;
    logic             w_issue;
    logic             w_set_en;
    logic             w_clr_hit;

    assign w_regs  = decode_regs(dec_insn);
    assign w_rd_nz = (w_regs.rd != '0);

    // One-hot clear (writeback) and set (long-latency issue) vectors.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_onehot
        assign w_clr[gi] = wb_valid & (wb_rd == reg_idx_t'(gi));
        assign w_set[gi] = w_set_en & (w_regs.rd == reg_idx_t'(gi));
    end

`ifdef YARVI_SB_WB_BYPASS_EN
    assign w_busy_chk = r_busy & ~w_clr;
`else
    assign w_busy_chk = r_busy;
`endif

    yarvi_sb_hazard #(
        .NREGS     (NREGS)
    ) u_hazard (
        .busy_chk  (w_busy_chk),
        .regs      (w_regs),
        .use_rs1   (dec_use_rs1),
        .use_rs2   (dec_use_rs2),
        .writes_rd (dec_writes_rd),
        .serialize (dec_serialize),
        .hazard    (w_hazard)
    );

    assign dec_ready = ~w_hazard & ~flush;
    assign w_issue   = dec_valid & dec_ready;
    // x0 never becomes busy, so w_set bit 0 is always clear.
    assign w_set_en  = w_issue & dec_long & dec_writes_rd & w_rd_nz;
    assign w_clr_hit = |(w_clr & r_busy);

    // Busy vector: flush kills everything, otherwise clear then set (set wins).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    // Pending-write count tracks the busy vector incrementally; never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case ({w_set_en, w_clr_hit})
                2'b10:   if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
                2'b01:   if (r_cnt != '0)      r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign busy        = r_busy;
    assign pending_cnt = r_cnt;
    assign quiescent   = (r_busy == '0);

`ifndef SYNTHESIS
    // Writebacks must target a busy, non-zero register.
    always_ff @(posedge clock) begin
        if (!reset && wb_valid) begin
            assert ((wb_rd != 5'd0) && r_busy[wb_rd]);
        end
    end
`ifndef YARVI_SB_WB_BYPASS_EN
    // Without bypass the WAW check makes same-register set+clear impossible.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert ((w_set & w_clr) == '0);
        end
    end
`endif
`endif

endmodule
